// File: rtl/mips_cpu_muldiv_sequencer.sv
// Multi-cycle MIPS multiply/divide sequencer and HI/LO register owner.
// Shift-add multiply and restoring divide, one bit per cycle over 32 cycles.
module mips_cpu_muldiv_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        stall,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FINISH
  } state_t;

  state_t      state_q;
  logic [4:0]  count_q;
  logic [63:0] acc_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        neg_quo_q;
  logic        neg_rem_q;
  logic        is_div_q;
  logic        busy_q;
  logic        done_q;

  logic        accept;
  logic        is_md;
  logic        sgn;
  logic        is_div;
  logic        a_neg;
  logic        b_neg;
  logic        div0;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [63:0] mul_d;
  logic [32:0] div_trial;
  logic [63:0] div_d;
  logic [63:0] prod_fin;
  logic [31:0] quo_fin;
  logic [31:0] rem_fin;

  always_comb begin
    accept = op_valid & (state_q == S_IDLE);
    is_md  = ~op[2];
    sgn    = op[1];
    is_div = ~op[0];
    a_neg  = sgn & rs_data[31];
    b_neg  = sgn & rt_data[31];
    a_mag  = a_neg ? (~rs_data + 32'd1) : rs_data;
    b_mag  = b_neg ? (~rt_data + 32'd1) : rt_data;
    div0   = is_div & (rt_data == 32'd0);
    // acc holds {partial product, multiplier} or {remainder, quotient}
    mul_sum = {1'b0, acc_q[63:32]}
            + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    mul_d   = {mul_sum, acc_q[31:1]};
    div_trial = acc_q[63:31] - {1'b0, b_q};
    div_d   = div_trial[32]
            ? {acc_q[62:0], 1'b0}
            : {div_trial[31:0], acc_q[30:0], 1'b1};
    prod_fin = neg_quo_q ? (~acc_q + 64'd1) : acc_q;
    quo_fin  = neg_quo_q ? (~acc_q[31:0] + 32'd1)
                         : acc_q[31:0];
    rem_fin  = neg_rem_q ? (~acc_q[63:32] + 32'd1)
                         : acc_q[63:32];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      count_q   <= 5'd0;
      acc_q     <= 64'd0;
      b_q       <= 32'd0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (accept && !is_md) begin
            if (op == 3'b100) hi_q <= rs_data;
            if (op == 3'b101) lo_q <= rs_data;
          end else if (accept && !div0) begin
            acc_q     <= {32'd0, a_mag};
            b_q       <= b_mag;
            neg_quo_q <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            is_div_q  <= is_div;
            count_q   <= 5'd31;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q   <= is_div_q ? div_d : mul_d;
          count_q <= count_q - 5'd1;
          if (count_q == 5'd0) begin
            state_q <= S_FINISH;
            done_q  <= 1'b1;
          end
        end
        S_FINISH: begin
          if (is_div_q) begin
            hi_q <= rem_fin;
            lo_q <= quo_fin;
          end else begin
            hi_q <= prod_fin[63:32];
            lo_q <= prod_fin[31:0];
          end
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall  = op_valid & (state_q != S_IDLE);
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = op[0] ? lo_q : hi_q;
  assign hi     = hi_q;
  assign lo     = lo_q;

endmodule

// File: tb/tb_mips_cpu_muldiv_sequencer.sv
// Directed and randomised checks for the mult/div sequencer.
module tb_mips_cpu_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  int tests = 0;
  int fails = 0;

  localparam logic [2:0] MULT  = 3'b011;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b000;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;
  localparam logic [2:0] MFHI  = 3'b110;
  localparam logic [2:0] MFLO  = 3'b111;

  mips_cpu_muldiv_sequencer dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .op       (op),
    .rs_data  (rs_data),
    .rt_data  (rt_data),
    .stall    (stall),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_md(input logic [2:0] o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    longint sp;
    int     q;
    int     r;
    ref_md = 64'd0;
    case (o)
      MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        ref_md = sp;
      end
      MULTU: ref_md = {32'd0, a} * {32'd0, b};
      DIV: begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          ref_md = {32'd0, 32'h8000_0000};
        end else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          ref_md = {r, q};
        end
      end
      default: ref_md = {a % b, a / b};
    endcase
  endfunction

  // Issues one mult/div at cycle 0 and checks every cycle up to cycle 34.
  task automatic run_md(input string tag,
                        input logic [2:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b);
    logic [63:0] exp;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int bad;
    exp = ref_md(o, a, b);
    old_hi = hi;
    old_lo = lo;
    op_valid = 1'b1;
    op = o;
    rs_data = a;
    rt_data = b;
    #1;
    check({tag, " accept stall"}, 64'(stall), 64'd0);
    tick();
    op_valid = 1'b0;
    bad = 0;
    for (int i = 1; i <= 33; i++) begin
      if (busy !== 1'b1) bad++;
      if (done !== (i == 33)) bad++;
      if (hi !== old_hi || lo !== old_lo) bad++;
      tick();
    end
    check({tag, " busy/done/hold"}, 64'(bad), 64'd0);
    check({tag, " idle after"}, {62'd0, busy, done}, 64'd0);
    check({tag, " hi:lo"}, {hi, lo}, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: pick = 32'h0000_0000;
      1: pick = 32'h0000_0001;
      2: pick = 32'hFFFF_FFFF;
      3: pick = 32'h7FFF_FFFF;
      4: pick = 32'h8000_0000;
      default: pick = $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [2:0]  ro;
    int bad;

    reset = 1'b1;
    op_valid = 1'b0;
    op = 3'b000;
    rs_data = 32'd0;
    rt_data = 32'd0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("reset hi:lo", {hi, lo}, 64'd0);
    check("reset busy/done", {62'd0, busy, done}, 64'd0);
    check("reset stall", 64'(stall), 64'd0);

    run_md("MULT -3*7", MULT, 32'hFFFF_FFFD, 32'd7);
    check("MULT -3*7 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);

    // MULTU with an MFLO presented from cycle 1
    op_valid = 1'b1;
    op = MULTU;
    rs_data = 32'hFFFF_FFFF;
    rt_data = 32'hFFFF_FFFF;
    tick();
    op = MFLO;
    #1;
    bad = 0;
    for (int i = 1; i <= 33; i++) begin
      if (stall !== 1'b1) bad++;
      tick();
    end
    check("MFLO stall 1..33", 64'(bad), 64'd0);
    check("MFLO stall c34", 64'(stall), 64'd0);
    check("MFLO result c34", 64'(result), 64'h0000_0001);
    check("MULTU hi:lo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    tick();
    op_valid = 1'b0;

    run_md("DIV -7/2", DIV, 32'hFFFF_FFF9, 32'd2);
    check("DIV -7/2 const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_md("DIVU 100/7", DIVU, 32'd100, 32'd7);
    check("DIVU 100/7 const", {hi, lo}, {32'd2, 32'd14});
    run_md("DIV min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("DIV min/-1 const", {hi, lo}, 64'h0000_0000_8000_0000);

    // MTHI then MFHI back to back
    op_valid = 1'b1;
    op = MTHI;
    rs_data = 32'h1234_5678;
    #1;
    check("MTHI stall", 64'(stall), 64'd0);
    tick();
    op = MFHI;
    #1;
    check("MFHI stall", 64'(stall), 64'd0);
    check("MFHI result", 64'(result), 64'h1234_5678);
    tick();
    op = MTLO;
    rs_data = 32'hCAFE_F00D;
    tick();

    // divide by zero leaves everything untouched
    op = DIVU;
    rs_data = 32'd5;
    rt_data = 32'd0;
    tick();
    op_valid = 1'b0;
    check("DIV0 busy", 64'(busy), 64'd0);
    tick();
    check("DIV0 busy/done", {62'd0, busy, done}, 64'd0);
    check("DIV0 hi:lo", {hi, lo}, 64'h1234_5678_CAFE_F00D);

    // reset in cycle 10 of a MULT
    op_valid = 1'b1;
    op = MULT;
    rs_data = 32'd123;
    rt_data = 32'd456;
    tick();
    op_valid = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    op_valid = 1'b1;
    op = MFHI;
    #1;
    check("mid reset busy/done", {62'd0, busy, done}, 64'd0);
    check("mid reset hi:lo", {hi, lo}, 64'd0);
    check("mid reset stall", 64'(stall), 64'd0);
    op_valid = 1'b0;
    run_md("MULTU after reset", MULTU, 32'd6, 32'd7);
    check("MULTU 6*7 const", {hi, lo}, 64'd42);

    // MTHI presented while busy lands after the FINISH write
    op_valid = 1'b1;
    op = MULTU;
    rs_data = 32'd3;
    rt_data = 32'd5;
    tick();
    op = MTHI;
    rs_data = 32'hAAAA_5555;
    repeat (33) tick();
    check("MT c34 stall", 64'(stall), 64'd0);
    check("MT c34 hi:lo", {hi, lo}, 64'd15);
    tick();
    op_valid = 1'b0;
    check("MT wins hi:lo", {hi, lo}, {32'hAAAA_5555, 32'd15});

    // new MULTU presented during FINISH waits one cycle
    op_valid = 1'b1;
    op = DIVU;
    rs_data = 32'd9;
    rt_data = 32'd2;
    tick();
    op_valid = 1'b0;
    repeat (32) tick();
    op_valid = 1'b1;
    op = MULTU;
    rs_data = 32'd3;
    rt_data = 32'd4;
    #1;
    check("FINISH stall/done", {62'd0, stall, done}, 64'd3);
    tick();
    check("c34 accept stall", 64'(stall), 64'd0);
    check("DIVU 9/2 hi:lo", {hi, lo}, {32'd1, 32'd4});
    tick();
    op_valid = 1'b0;
    check("second op busy", 64'(busy), 64'd1);
    repeat (33) tick();
    check("MULTU 3*4 hi:lo", {hi, lo}, 64'd12);

    for (int n = 0; n < 24; n++) begin
      ro = {1'b0, 2'($urandom_range(0, 3))};
      ra = pick();
      rb = pick();
      if (!ro[0] && rb == 32'd0) rb = 32'd3;
      run_md($sformatf("rand%0d op%0d", n, ro), ro, ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mips_cpu_muldiv_sequencer.md
# mips_cpu_muldiv_sequencer

Multi-cycle multiply/divide engine and HI/LO register owner for the MIPS CPU. It takes the 3-bit mult/div opcode produced by ALU control, plus the rs/rt operand values, and sequences 32-iteration shift-add multiply and restoring divide. It also services MTHI/MTLO/MFHI/MFLO, and stalls the pipeline while an operation is in flight.

## Interface
Parameters:
- none. Datapath width is fixed at 32 bits and the iteration count at 32.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  opcode/operands valid this cycle; CPU holds them stable while stall=1
- op  in  3  011 MULT, 001 MULTU, 010 DIV, 000 DIVU, 100 MTHI, 101 MTLO, 110 MFHI, 111 MFLO
- rs_data  in  32  operand A (dividend/multiplicand; MTHI/MTLO source)
- rt_data  in  32  operand B (divisor/multiplier)
- stall  out  1  combinational; = op_valid AND state≠IDLE
- busy  out  1  registered; high in RUN and FINISH
- done  out  1  high for exactly the FINISH cycle
- result  out  32  combinational; op[0]=1 → lo, op[0]=0 → hi (meaningful only for an accepted MFHI/MFLO)
- hi, lo  out  32 each  architectural HI/LO registers

## Operation
- States: IDLE, RUN, FINISH.
- Accept: op_valid=1 in IDLE. Requests are never accepted in RUN or FINISH.
- MTHI/MTLO accepted: hi (or lo) ← rs_data at that edge. State stays IDLE.
- MFHI/MFLO accepted: result is valid in the same cycle; no state change.
- MULT/MULTU/DIV/DIVU accepted:
  - Latch operand magnitudes: abs() for signed ops, raw for unsigned.
  - Latch neg_q = sign(rs) XOR sign(rt) and neg_r = sign(rs); both are 0 for unsigned ops.
  - Load count=31 and go to RUN.
- Divide by zero (DIV/DIVU with rt_data=0): accepted but does nothing. hi/lo unchanged, state stays IDLE, done not asserted.
- RUN, multiply: 64-bit product accumulator, one conditional add + shift per cycle.
- RUN, divide: restoring divide, one quotient bit per cycle; 33-bit trial subtract of the remainder.
- RUN advance: count decrements each cycle; when count=0 the next state is FINISH.
- FINISH:
  - Apply sign correction as 64-bit (product) or 32-bit (quotient/remainder) two's-complement negate.
  - Write hi/lo at the FINISH edge, then return to IDLE.
- Result mapping: multiply → {hi,lo} = 64-bit product. Divide → lo = quotient, hi = remainder.
- Remainder sign follows the dividend; quotient truncates toward zero.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. This falls out of the magnitude method; no special case.
- Operand latches and partial state are internal. hi/lo are never visible mid-operation; they change only at the FINISH edge.

## Timing
- Reset: state=IDLE, hi=0, lo=0, busy=0, done=0, count=0. Any in-flight operation is discarded; hi/lo are cleared, not written.
- Reset dominates op_valid in the same cycle.
- Mult/div latency, with cycle 0 = accept cycle:
  - RUN occupies cycles 1–32; FINISH is cycle 33 (busy=1 for 33 cycles).
  - hi/lo hold the new values from cycle 34.
  - The earliest next accept is cycle 34.
- An MFHI/MFLO presented during cycles 1–33 stalls and is accepted in cycle 34, returning the new value.
- An MTHI/MTLO presented during busy stalls in the same way. Its write then lands after the FINISH write, so the MT value wins.
- A new MULT/DIV presented during FINISH stalls one cycle and is accepted in cycle 34.
- stall is 0 whenever op_valid=0, regardless of state.

## Test plan
- MULT rs=0xFFFFFFFD (-3), rt=7 → busy high 33 cycles, done one-cycle pulse at cycle 33, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Follow with MFLO issued in cycle 1 → stall=1 for cycles 1–33, result=0x00000001 in cycle 34.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100 / 7 → lo=14, hi=2. DIV 0x80000000 / -1 → lo=0x80000000, hi=0.
- MTHI 0x12345678, then MFHI next cycle → no stall, result=0x12345678. DIVU x/0 with hi/lo preset → hi/lo unchanged, busy stays 0.
- Assert reset in cycle 10 of a MULT → next cycle state=IDLE, busy=0, hi=lo=0. A new MULTU accepted immediately afterwards completes correctly.
- Randomised back-to-back signed/unsigned mult/div, including 0, 1, -1, 0x7FFFFFFF and 0x80000000 operands, checked against a reference model.
